// File: rtl/uart_rx_pkg.sv
// Shared UART RX definitions: FSM state encoding, per-word status bundle and the
// parity rule (also used by the TX framer). No logic, no latency, no flow control.
package uart_rx_pkg;

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_DATA     = 3'd1,
    ST_PARITY   = 3'd2,
    ST_STOP     = 3'd3,
    ST_BRK_WAIT = 3'd4
  } rx_state_e;

  typedef struct packed {
    logic perr;
    logic ferr;
    logic brk;
  } rx_status_t;

  // Stick mode forces the bit to ~eps; otherwise even/odd over the data bits.
  function automatic logic parity_bit(input logic pen, input logic eps,
                                      input logic sp, input logic acc);
    if (!pen) return 1'b0;
    return sp ? ~eps : (eps ? acc : ~acc);
  endfunction

endpackage

// File: rtl/uart_rx_out_reg.sv
// Single-entry word+status holding register; loads one cycle after load_vld.
// A load while full and not draining drops the new word and pulses overrun.
module uart_rx_out_reg
  import uart_rx_pkg::*;
#(
  parameter int DATA_W = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              load_vld,
  input  logic [DATA_W-1:0] load_dat,
  input  rx_status_t        load_sts,
  input  logic              rx_ready,
  output logic              rx_valid,
  output logic [DATA_W-1:0] rx_data,
  output rx_status_t        rx_sts,
  output logic              overrun
);

  logic can_load;

  assign can_load = ~rx_valid | rx_ready;

  always_ff @(posedge clk) begin
    if (rst) begin
      rx_valid <= 1'b0;
      rx_data  <= '0;
      rx_sts   <= '0;
      overrun  <= 1'b0;
    end else begin
      overrun <= 1'b0;
      if (load_vld) begin
        if (can_load) begin
          rx_valid <= 1'b1;
          rx_data  <= load_dat;
          rx_sts   <= load_sts;
        end else begin
          overrun  <= 1'b1;
        end
      end else if (rx_valid && rx_ready) begin
        rx_valid <= 1'b0;
      end
    end
  end

endmodule

// File: rtl/uart_rx_deframer.sv
// UART receive deframer: start/data/parity/stop from mid-bit samples, one bit per cycle.
// Word valid one cycle after the stop-bit sample; held until rx_ready, overrun on drop.
module uart_rx_deframer
  import uart_rx_pkg::*;
#(
  parameter int DATA_W = 8,
  parameter int WLS_W  = $clog2(DATA_W)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              bit_valid,
  input  logic              bit_in,
  input  logic [WLS_W-1:0]  wls,
  input  logic              pen,
  input  logic              eps,
  input  logic              sp,
  input  logic              rx_ready,
  output logic              rx_valid,
  output logic [DATA_W-1:0] rx_data,
  output logic              parity_error,
  output logic              framing_error,
  output logic              break_int,
  output logic              overrun,
  output logic              busy
);

  localparam int CNT_W = $clog2(DATA_W);

  localparam logic [2:0] IDLE     = ST_IDLE;
  localparam logic [2:0] DATA     = ST_DATA;
  localparam logic [2:0] PARITY   = ST_PARITY;
  localparam logic [2:0] STOP     = ST_STOP;
  localparam logic [2:0] BRK_WAIT = ST_BRK_WAIT;

  logic [2:0]        state_q;
  logic [CNT_W-1:0]  cnt_q;
  logic [CNT_W-1:0]  wls_q;
  logic [CNT_W-1:0]  wls_eff;
  logic [DATA_W-1:0] shift_q;
  logic              acc_q;
  logic              ones_q;
  logic              perr_q;
  logic              pen_q;
  logic              eps_q;
  logic              sp_q;

  logic              frame_done;
  logic              brk_now;
  rx_status_t        sts_now;
  rx_status_t        rx_sts;

  // Word lengths beyond DATA_W are only reachable when DATA_W is not a power of two.
  if ((1 << WLS_W) > DATA_W) begin : g_wls_clamp
    assign wls_eff = (wls > WLS_W'(DATA_W - 1)) ? CNT_W'(DATA_W - 1) : CNT_W'(wls);
  end else begin : g_wls_direct
    assign wls_eff = CNT_W'(wls);
  end

  always_comb begin
    frame_done = bit_valid && (state_q == STOP);
    brk_now    = ~ones_q & ~bit_in;
    sts_now    = '{perr: perr_q, ferr: ~bit_in, brk: brk_now};
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      wls_q   <= '0;
      shift_q <= '0;
      acc_q   <= 1'b0;
      ones_q  <= 1'b0;
      perr_q  <= 1'b0;
      pen_q   <= 1'b0;
      eps_q   <= 1'b0;
      sp_q    <= 1'b0;
    end else if (bit_valid) begin
      case (state_q)
        IDLE: begin
          if (!bit_in) begin
            wls_q   <= wls_eff;
            pen_q   <= pen;
            eps_q   <= eps;
            sp_q    <= sp;
            cnt_q   <= '0;
            shift_q <= '0;
            acc_q   <= 1'b0;
            ones_q  <= 1'b0;
            perr_q  <= 1'b0;
            state_q <= DATA;
          end
        end
        DATA: begin
          shift_q[cnt_q] <= bit_in;
          acc_q          <= acc_q ^ bit_in;
          ones_q         <= ones_q | bit_in;
          cnt_q          <= cnt_q + CNT_W'(1);
          if (cnt_q == wls_q) state_q <= pen_q ? PARITY : STOP;
        end
        PARITY: begin
          perr_q  <= bit_in != parity_bit(pen_q, eps_q, sp_q, acc_q);
          ones_q  <= ones_q | bit_in;
          state_q <= STOP;
        end
        STOP: begin
          // An all-zero frame means the line is held low; wait for it to recover.
          state_q <= brk_now ? BRK_WAIT : IDLE;
        end
        BRK_WAIT: begin
          if (bit_in) state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  uart_rx_out_reg #(
    .DATA_W (DATA_W)
  ) u_out_reg (
    .clk      (clk),
    .rst      (rst),
    .load_vld (frame_done),
    .load_dat (shift_q),
    .load_sts (sts_now),
    .rx_ready (rx_ready),
    .rx_valid (rx_valid),
    .rx_data  (rx_data),
    .rx_sts   (rx_sts),
    .overrun  (overrun)
  );

  assign parity_error  = rx_sts.perr;
  assign framing_error = rx_sts.ferr;
  assign break_int     = rx_sts.brk;
  assign busy          = (state_q != IDLE);

endmodule

// File: tb/tb_uart_rx_deframer.sv
// Randomized bench for uart_rx_deframer: frames built from word/parity rules,
// expected words tracked as a one-deep output slot with drop-on-full.
`timescale 1ns/1ps
module tb_uart_rx_deframer;

  localparam int DATA_W = 8;
  localparam int WLS_W  = 3;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic              bit_valid = 1'b0;
  logic              bit_in = 1'b1;
  logic [WLS_W-1:0]  wls = '0;
  logic              pen = 1'b0;
  logic              eps = 1'b0;
  logic              sp = 1'b0;
  logic              rx_ready = 1'b0;
  logic              rx_valid;
  logic [DATA_W-1:0] rx_data;
  logic              parity_error;
  logic              framing_error;
  logic              break_int;
  logic              overrun;
  logic              busy;

  uart_rx_deframer #(
    .DATA_W (DATA_W),
    .WLS_W  (WLS_W)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .bit_valid     (bit_valid),
    .bit_in        (bit_in),
    .wls           (wls),
    .pen           (pen),
    .eps           (eps),
    .sp            (sp),
    .rx_ready      (rx_ready),
    .rx_valid      (rx_valid),
    .rx_data       (rx_data),
    .parity_error  (parity_error),
    .framing_error (framing_error),
    .break_int     (break_int),
    .overrun       (overrun),
    .busy          (busy)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Driver-side config and the expected result of the frame whose stop bit is in flight.
  int         cfg_wls = 7;
  logic       cfg_pen = 1'b0, cfg_eps = 1'b0, cfg_sp = 1'b0;
  int         ready_mode = 1;
  int         busy_exp = -1;
  logic       drv_last = 1'b0;
  logic [7:0] nxt_data = '0, exp_data = '0;
  logic       nxt_perr = 1'b0, nxt_ferr = 1'b0, nxt_brk = 1'b0;
  logic       exp_perr = 1'b0, exp_ferr = 1'b0, exp_brk = 1'b0;

  // Output slot: a finished frame lands if the slot is free or being taken this cycle.
  logic       m_full = 1'b0, m_ovr = 1'b0;
  logic [7:0] m_data = '0;
  logic       m_perr = 1'b0, m_ferr = 1'b0, m_brk = 1'b0;

  always @(posedge clk) begin
    if (rst) begin
      m_full = 1'b0; m_ovr = 1'b0; m_data = '0;
      m_perr = 1'b0; m_ferr = 1'b0; m_brk = 1'b0;
    end else begin
      m_ovr = 1'b0;
      if (bit_valid && drv_last) begin
        if (!m_full || rx_ready) begin
          m_full = 1'b1; m_data = exp_data;
          m_perr = exp_perr; m_ferr = exp_ferr; m_brk = exp_brk;
        end else begin
          m_ovr = 1'b1;
        end
      end else if (m_full && rx_ready) begin
        m_full = 1'b0;
      end
    end
  end

  task automatic tick(input logic bv, input logic bi, input logic last);
    @(negedge clk);
    check_eq("rx_valid",      32'(rx_valid),      32'(m_full));
    check_eq("overrun",       32'(overrun),       32'(m_ovr));
    check_eq("rx_data",       32'(rx_data),       32'(m_data));
    check_eq("parity_error",  32'(parity_error),  32'(m_perr));
    check_eq("framing_error", 32'(framing_error), 32'(m_ferr));
    check_eq("break_int",     32'(break_int),     32'(m_brk));
    if (busy_exp >= 0) begin
      check_eq("busy", 32'(busy), 32'(busy_exp));
      busy_exp = -1;
    end
    bit_valid = bv;
    bit_in    = bi;
    drv_last  = last;
    if (last) begin
      exp_data = nxt_data; exp_perr = nxt_perr; exp_ferr = nxt_ferr; exp_brk = nxt_brk;
    end
    wls = cfg_wls[WLS_W-1:0];
    pen = cfg_pen;
    eps = cfg_eps;
    sp  = cfg_sp;
    case (ready_mode)
      0:       rx_ready = 1'b0;
      1:       rx_ready = 1'b1;
      default: rx_ready = 1'($urandom_range(0, 1));
    endcase
  endtask

  task automatic gap();
    int n;
    n = $urandom_range(0, 2);
    repeat (n) tick(1'b0, 1'($urandom_range(0, 1)), 1'b0);
  endtask

  task automatic send_frame(input logic [7:0] d, input int w, input logic p_en,
                            input logic e, input logic s, input logic flip,
                            input logic stop_b, input logic scramble);
    logic [7:0] md;
    int         ones;
    int         nz;
    logic       par_ok, par_sent;
    md   = d & 8'((1 << (w + 1)) - 1);
    ones = $countones(md);
    if (s)      par_ok = !e;
    else if (e) par_ok = (ones % 2) == 1;
    else        par_ok = (ones % 2) == 0;
    par_sent = par_ok ^ flip;
    nxt_data = md;
    nxt_perr = p_en & flip;
    nxt_ferr = !stop_b;
    nxt_brk  = (md == 8'h00) && !(p_en && par_sent) && !stop_b;
    cfg_wls = w; cfg_pen = p_en; cfg_eps = e; cfg_sp = s;
    gap();
    tick(1'b1, 1'b0, 1'b0);
    busy_exp = 1;
    for (int i = 0; i <= w; i++) begin
      if (scramble) begin
        cfg_wls = $urandom_range(0, 7);
        cfg_pen = 1'($urandom_range(0, 1));
        cfg_eps = 1'($urandom_range(0, 1));
        cfg_sp  = 1'($urandom_range(0, 1));
      end
      gap();
      tick(1'b1, md[i], 1'b0);
    end
    if (p_en) begin
      gap();
      tick(1'b1, par_sent, 1'b0);
    end
    gap();
    tick(1'b1, stop_b, 1'b1);
    busy_exp = nxt_brk ? 1 : 0;
    if (nxt_brk) begin
      nz = $urandom_range(1, 3);
      repeat (nz) begin
        gap();
        tick(1'b1, 1'b0, 1'b0);
      end
      busy_exp = 1;
      gap();
      tick(1'b1, 1'b1, 1'b0);
      busy_exp = 0;
    end
  endtask

  initial begin
    logic [7:0] rd;
    int         rw;

    repeat (3) @(negedge clk);
    check_eq("rst_rx_valid", 32'(rx_valid), 32'd0);
    check_eq("rst_rx_data",  32'(rx_data),  32'd0);
    check_eq("rst_perr",     32'(parity_error),  32'd0);
    check_eq("rst_ferr",     32'(framing_error), 32'd0);
    check_eq("rst_brk",      32'(break_int), 32'd0);
    check_eq("rst_overrun",  32'(overrun),   32'd0);
    check_eq("rst_busy",     32'(busy),      32'd0);
    rst = 1'b0;

    ready_mode = 1;
    send_frame(8'hA5, 7, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0);
    send_frame(8'hA5, 7, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0);
    send_frame(8'hA5, 7, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0);
    send_frame(8'h13, 4, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1);
    send_frame(8'h00, 7, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    send_frame(8'h3C, 7, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0);
    tick(1'b0, 1'b1, 1'b0);

    ready_mode = 0;
    send_frame(8'h11, 7, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    send_frame(8'h22, 7, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    repeat (2) tick(1'b0, 1'b1, 1'b0);
    ready_mode = 1;
    repeat (3) tick(1'b0, 1'b1, 1'b0);

    // Abort a frame after three data bits.
    cfg_wls = 7; cfg_pen = 1'b0; cfg_eps = 1'b0; cfg_sp = 1'b0;
    tick(1'b1, 1'b0, 1'b0);
    tick(1'b1, 1'b1, 1'b0);
    tick(1'b1, 1'b0, 1'b0);
    tick(1'b1, 1'b1, 1'b0);
    @(negedge clk);
    rst = 1'b1; bit_valid = 1'b0; drv_last = 1'b0;
    @(negedge clk);
    check_eq("mid_rst_busy",     32'(busy),     32'd0);
    check_eq("mid_rst_rx_valid", 32'(rx_valid), 32'd0);
    check_eq("mid_rst_rx_data",  32'(rx_data),  32'd0);
    check_eq("mid_rst_status",   32'({parity_error, framing_error, break_int}), 32'd0);
    check_eq("mid_rst_overrun",  32'(overrun),  32'd0);
    rst = 1'b0;
    send_frame(8'h5A, 7, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0);

    for (int f = 0; f < 250; f++) begin
      rw = $urandom_range(0, 7);
      rd = ($urandom_range(0, 4) == 0) ? 8'h00 : 8'($urandom);
      ready_mode = $urandom_range(0, 2);
      send_frame(rd, rw, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                 1'($urandom_range(0, 1)), ($urandom_range(0, 3) == 0),
                 ($urandom_range(0, 4) != 0), 1'($urandom_range(0, 1)));
      if ($urandom_range(0, 2) == 0) tick(1'b1, 1'b1, 1'b0);
    end

    ready_mode = 1;
    repeat (4) tick(1'b0, 1'b1, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
